io_unit: RTL and testbench

IO_UNIT -- requirements
Module: io_unit

---
 rtl/mycpu_pkg.sv | 24 ++
 rtl/io_fifo.sv | 67 ++++++
 rtl/io_unit.sv | 150 +++++++++++++++
 tb/tb_io_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared constants for the memory-mapped IO unit: register map, STATUS
// bit positions and RX FIFO sizing.
package mycpu_pkg;

    // Register map, decoded from addr_in[1:0]
    typedef enum logic [1:0] {
        IO_RXDATA = 2'd0,
        IO_TXDATA = 2'd1,
        IO_STATUS = 2'd2,
        IO_TIMER  = 2'd3
    } io_reg_e;

    localparam int unsigned IO_DATA_W     = 16;

    // RX FIFO sizing
    localparam int unsigned IO_FIFO_DEPTH = 4;
    localparam int unsigned IO_FIFO_CNT_W = $clog2(IO_FIFO_DEPTH + 1);

    // STATUS register bit positions; rx_count occupies [2:0]
    localparam int unsigned STAT_TX_VALID   = 3;
    localparam int unsigned STAT_TX_OVR     = 4;
    localparam int unsigned STAT_TIMER_DONE = 5;

endpackage

// File: rtl/io_fifo.sv
// Synchronous RX buffer for io_unit. Push is ignored when full and pop is
// ignored when empty; pointers wrap modulo DEPTH.
module io_fifo
    import mycpu_pkg::*;
#(
    parameter int unsigned DEPTH = IO_FIFO_DEPTH,
    parameter int unsigned W     = IO_DATA_W
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              push,
    input  logic                              pop,
    input  logic [W-1:0]                      wdata,
    output logic [W-1:0]                      rdata,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(DEPTH + 1)-1:0]      count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rptr];

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= ptr_next(wptr);
            end
            if (pop_ok) begin
                rptr <= ptr_next(rptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_unit.sv
// Memory-mapped IO unit: RXDATA/TXDATA/STATUS/TIMER registers, a 4-entry
// RX FIFO and a single-word TX holding register with overrun flag.
// Optional down-counter timer enabled by defining IO_UNIT_TIMER_EN.
module io_unit
    import mycpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    // CPU side
    input  logic        iom_in,
    input  logic        wen_in,
    input  logic        rd_in,
    input  logic [15:0] addr_in,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    // RX side
    input  logic        rx_valid_in,
    input  logic [15:0] rx_data_in,
    output logic        rx_ready_out,
    // TX side
    output logic        tx_valid_out,
    output logic [15:0] tx_data_out,
    input  logic        tx_ready_in
);

    io_reg_e                  reg_sel;
    logic                     rd_act;
    logic                     wr_act;
    logic                     rd_eff;
    logic                     rx_pop;
    logic                     rx_push;
    logic [15:0]              rx_rdata;
    logic                     rx_full;
    logic                     rx_empty;
    logic [IO_FIFO_CNT_W-1:0] rx_count;
    logic                     tx_wr;
    logic                     tx_load;
    logic                     tx_ovr;
    logic                     ovr_set;
    logic                     ovr_clr;
    logic [15:0]              status;
    logic [15:0]              timer_val;
    logic                     timer_done;
    logic                     unused_addr;

    // Upper address bits are not decoded
    assign unused_addr = ^addr_in[15:2];

    assign reg_sel = io_reg_e'(addr_in[1:0]);
    assign rd_act  = iom_in & rd_in;
    assign wr_act  = iom_in & ~wen_in;
    // A write in the same cycle suppresses the read's side effects
    assign rd_eff  = rd_act & ~wr_act;

    assign rx_ready_out = ~rx_full;
    assign rx_push      = rx_valid_in & rx_ready_out;
    assign rx_pop       = rd_eff & (reg_sel == IO_RXDATA);

    io_fifo #(
        .DEPTH (IO_FIFO_DEPTH),
        .W     (IO_DATA_W)
    ) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (rx_data_in),
        .rdata (rx_rdata),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    assign tx_wr   = wr_act & (reg_sel == IO_TXDATA);
    assign tx_load = tx_wr & (~tx_valid_out | tx_ready_in);
    assign ovr_set = tx_wr & tx_valid_out & ~tx_ready_in;
    assign ovr_clr = wr_act & (reg_sel == IO_STATUS) & data_in[STAT_TX_OVR];

    // TX holding register: load when free or draining, clear on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid_out <= 1'b0;
            tx_data_out  <= '0;
        end else if (tx_load) begin
            tx_valid_out <= 1'b1;
            tx_data_out  <= data_in;
        end else if (tx_ready_in) begin
            tx_valid_out <= 1'b0;
        end
    end

    // Overrun flag; a set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ovr <= 1'b0;
        end else if (ovr_set) begin
            tx_ovr <= 1'b1;
        end else if (ovr_clr) begin
            tx_ovr <= 1'b0;
        end
    end

`ifdef IO_UNIT_TIMER_EN
    logic timer_wr;
    logic done_clr;

    assign timer_wr = wr_act & (reg_sel == IO_TIMER);
    assign done_clr = wr_act & (reg_sel == IO_STATUS) & data_in[STAT_TIMER_DONE];

    // Down-counter: load on write, decrement while nonzero, flag on 1->0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_val  <= '0;
            timer_done <= 1'b0;
        end else if (timer_wr) begin
            timer_val  <= data_in;
            timer_done <= 1'b0;
        end else begin
            if (timer_val != '0) begin
                timer_val <= timer_val - 1'b1;
            end
            if (timer_val == 16'd1) begin
                timer_done <= 1'b1;
            end else if (done_clr) begin
                timer_done <= 1'b0;
            end
        end
    end
`else
    assign timer_val  = '0;
    assign timer_done = 1'b0;
`endif

    assign status = {10'b0, timer_done, tx_ovr, tx_valid_out, rx_count[2:0]};

    // Read mux; zero whenever no read is active
    always_comb begin
        data_out = '0;
        if (rd_act) begin
            case (reg_sel)
                IO_RXDATA: data_out = rx_empty ? '0 : rx_rdata;
                IO_TXDATA: data_out = '0;
                IO_STATUS: data_out = status;
                IO_TIMER:  data_out = timer_val;
                default:   data_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_unit.sv
// Self-checking bench for io_unit: directed steps with an RX scoreboard
// queue. Define IO_UNIT_TIMER_EN for both DUT and bench to test the timer.
module tb_io_unit;
    import mycpu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        iom_in;
    logic        wen_in;
    logic        rd_in;
    logic [15:0] addr_in;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        rx_valid_in;
    logic [15:0] rx_data_in;
    logic        rx_ready_out;
    logic        tx_valid_out;
    logic [15:0] tx_data_out;
    logic        tx_ready_in;

    int checks   = 0;
    int failures = 0;
    logic [15:0] rxq[$];
    logic [15:0] rd_val;

    io_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .iom_in       (iom_in),
        .wen_in       (wen_in),
        .rd_in        (rd_in),
        .addr_in      (addr_in),
        .data_in      (data_in),
        .data_out     (data_out),
        .rx_valid_in  (rx_valid_in),
        .rx_data_in   (rx_data_in),
        .rx_ready_out (rx_ready_out),
        .tx_valid_out (tx_valid_out),
        .tx_data_out  (tx_data_out),
        .tx_ready_in  (tx_ready_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle starting at a falling edge; scoreboards RX push/pop
    task automatic bus(input logic rd, input logic wr, input logic [1:0] a,
                       input logic [15:0] wd, input logic push,
                       input logic [15:0] pd, output logic [15:0] d);
        logic [15:0] exp;
        logic        acc;
        iom_in      = rd | wr;
        rd_in       = rd;
        wen_in      = ~wr;
        addr_in     = {14'($urandom), a};
        data_in     = wd;
        rx_valid_in = push;
        rx_data_in  = pd;
        #1;
        d   = data_out;
        acc = push && (rxq.size() < 4);
        chk("rx_ready", {15'b0, rx_ready_out}, {15'b0, (rxq.size() < 4)});
        if (rd && !wr && a == 2'd0) begin
            exp = (rxq.size() > 0) ? rxq.pop_front() : 16'h0000;
            chk("rxdata", d, exp);
        end
        if (acc) rxq.push_back(pd);
        @(posedge clk);
        #1;
        iom_in      = 1'b0;
        rd_in       = 1'b0;
        wen_in      = 1'b1;
        rx_valid_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [15:0] d);
        bus(1'b1, 1'b0, a, 16'h0, 1'b0, 16'h0, d);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [15:0] wd);
        logic [15:0] d;
        bus(1'b0, 1'b1, a, wd, 1'b0, 16'h0, d);
    endtask

    task automatic rx_push(input logic [15:0] pd);
        logic [15:0] d;
        bus(1'b0, 1'b0, 2'd0, 16'h0, 1'b1, pd, d);
    endtask

    task automatic idle();
        logic [15:0] d;
        bus(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 16'h0, d);
    endtask

    initial begin
        rst_n       = 1'b0;
        iom_in      = 1'b0;
        wen_in      = 1'b1;
        rd_in       = 1'b0;
        addr_in     = '0;
        data_in     = '0;
        rx_valid_in = 1'b0;
        rx_data_in  = '0;
        tx_ready_in = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_rx_ready", {15'b0, rx_ready_out}, 16'h0001);
        chk("rst_tx_valid", {15'b0, tx_valid_out}, 16'h0000);
        chk("rst_tx_data", tx_data_out, 16'h0000);
        chk("rst_data_out", data_out, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        rd_reg(IO_STATUS, rd_val);
        chk("status_after_reset", rd_val, 16'h0000);

        // Fill FIFO, overflow attempt, drain in order, empty read
        rx_push(16'h1111);
        rx_push(16'h2222);
        rx_push(16'h3333);
        rx_push(16'h4444);
        chk("rx_ready_full", {15'b0, rx_ready_out}, 16'h0000);
        rx_push(16'h5555);
        rd_reg(IO_STATUS, rd_val);
        chk("status_full", rd_val, 16'h0004);
        for (int i = 0; i < 5; i++) rd_reg(IO_RXDATA, rd_val);
        rd_reg(IO_STATUS, rd_val);
        chk("status_drained", rd_val, 16'h0000);

        // TX hold, overrun, overrun clear, reload on accept, drain
        wr_reg(IO_TXDATA, 16'hABCD);
        for (int i = 0; i < 3; i++) begin
            chk("tx_valid_hold", {15'b0, tx_valid_out}, 16'h0001);
            chk("tx_data_hold", tx_data_out, 16'hABCD);
            idle();
        end
        wr_reg(IO_TXDATA, 16'h5555);
        chk("tx_data_not_overwritten", tx_data_out, 16'hABCD);
        rd_reg(IO_STATUS, rd_val);
        chk("status_ovr", rd_val, 16'h0018);
        wr_reg(IO_STATUS, 16'h0010);
        rd_reg(IO_STATUS, rd_val);
        chk("status_ovr_cleared", rd_val, 16'h0008);
        tx_ready_in = 1'b1;
        wr_reg(IO_TXDATA, 16'h1234);
        chk("tx_reload_valid", {15'b0, tx_valid_out}, 16'h0001);
        chk("tx_reload_data", tx_data_out, 16'h1234);
        idle();
        chk("tx_drained", {15'b0, tx_valid_out}, 16'h0000);
        tx_ready_in = 1'b0;
        rd_reg(IO_STATUS, rd_val);
        chk("status_no_ovr", rd_val, 16'h0000);

        // Simultaneous push/pop, read+write on RXDATA, RXDATA write ignored
        rx_push(16'hA001);
        rx_push(16'hA002);
        bus(1'b1, 1'b0, IO_RXDATA, 16'h0, 1'b1, 16'hA003, rd_val);
        rd_reg(IO_STATUS, rd_val);
        chk("status_push_pop", rd_val, 16'h0002);
        bus(1'b1, 1'b1, IO_RXDATA, 16'hDEAD, 1'b0, 16'h0, rd_val);
        rd_reg(IO_STATUS, rd_val);
        chk("status_rd_wr_no_pop", rd_val, 16'h0002);
        rd_reg(IO_RXDATA, rd_val);
        rd_reg(IO_RXDATA, rd_val);
        rd_reg(IO_RXDATA, rd_val);

        // Timer
        wr_reg(IO_TIMER, 16'd3);
`ifdef IO_UNIT_TIMER_EN
        rd_reg(IO_TIMER, rd_val);
        chk("timer_3", rd_val, 16'd3);
        rd_reg(IO_STATUS, rd_val);
        chk("timer_not_done", rd_val, 16'h0000);
        rd_reg(IO_TIMER, rd_val);
        chk("timer_1", rd_val, 16'd1);
        rd_reg(IO_STATUS, rd_val);
        chk("timer_done", rd_val, 16'h0020);
        rd_reg(IO_TIMER, rd_val);
        chk("timer_0", rd_val, 16'd0);
        wr_reg(IO_STATUS, 16'h0020);
        rd_reg(IO_STATUS, rd_val);
        chk("timer_done_cleared", rd_val, 16'h0000);
`else
        rd_reg(IO_TIMER, rd_val);
        chk("timer_disabled_read", rd_val, 16'h0000);
        idle();
        idle();
        rd_reg(IO_STATUS, rd_val);
        chk("timer_disabled_status", rd_val, 16'h0000);
`endif

        // Asynchronous reset mid-operation
        rx_push(16'hB001);
        rx_push(16'hB002);
        rx_push(16'hB003);
        wr_reg(IO_TXDATA, 16'h7777);
        rd_reg(IO_STATUS, rd_val);
        chk("status_before_reset", rd_val, 16'h000B);
        #2;
        rst_n   = 1'b0;
        iom_in  = 1'b1;
        rd_in   = 1'b1;
        addr_in = {14'h0, IO_STATUS};
        #1;
        chk("async_rx_ready", {15'b0, rx_ready_out}, 16'h0001);
        chk("async_tx_valid", {15'b0, tx_valid_out}, 16'h0000);
        chk("async_tx_data", tx_data_out, 16'h0000);
        chk("async_status", data_out, 16'h0000);
        iom_in = 1'b0;
        rd_in  = 1'b0;
        rxq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        chk("post_reset_tx_valid", {15'b0, tx_valid_out}, 16'h0000);
        rd_reg(IO_STATUS, rd_val);
        chk("post_reset_status", rd_val, 16'h0000);
        rd_reg(IO_RXDATA, rd_val);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
